// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait states, then a valid/ready response.
// Optional per-byte store strobes when DMEM_BYTE_STROBE_EN is defined.
module dmem_responder #(
   parameter int                        ADDR_BUS_WIDTH = 32,
   parameter int                        DATA_BUS_WIDTH = 32,
   parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDR      = 32'h0000_2000,
   parameter int                        DEPTH_WORDS    = 64,
   parameter int                        WAIT_STATES    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
   input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [3:0]                req_wstrb,
`endif
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
   output logic                      rsp_err
);

   localparam int                        IDX_W        = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_BUS_WIDTH-1:0] WINDOW_BYTES = ADDR_BUS_WIDTH'(DEPTH_WORDS * 4);
   localparam logic [3:0]                WAIT_INIT    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                    state;
   logic [3:0]                cnt;
   logic                      lat_write;
   logic [ADDR_BUS_WIDTH-1:0] lat_addr;
   logic [DATA_BUS_WIDTH-1:0] lat_wdata;
   logic [3:0]                lat_strb;
   logic [DATA_BUS_WIDTH-1:0] mem [DEPTH_WORDS];

   logic [3:0]                in_strb;
   logic                      a_write;
   logic [ADDR_BUS_WIDTH-1:0] a_addr;
   logic [ADDR_BUS_WIDTH-1:0] a_off;
   logic [DATA_BUS_WIDTH-1:0] a_wdata;
   logic [3:0]                a_strb;
   logic                      a_legal;
   logic [IDX_W-1:0]          a_idx;
   logic                      do_access;
   logic                      mem_we;

`ifdef DMEM_BYTE_STROBE_EN
   assign in_strb = req_wstrb;
`else
   assign in_strb = 4'hF;
`endif

   // With zero wait states the access happens on the accepting edge, so it must use the live request.
   assign a_write = (state == IDLE) ? req_write : lat_write;
   assign a_addr  = (state == IDLE) ? req_addr  : lat_addr;
   assign a_wdata = (state == IDLE) ? req_wdata : lat_wdata;
   assign a_strb  = (state == IDLE) ? in_strb   : lat_strb;

   // Wrap-around subtraction: addresses below the base give a huge offset, caught by the >= test too.
   assign a_off   = a_addr - BASE_ADDR;
   assign a_legal = (a_addr >= BASE_ADDR) && (a_off < WINDOW_BYTES) && (a_off[1:0] == 2'b00);
   assign a_idx   = a_off[IDX_W+1:2];

   assign do_access = ((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                      ((state == BUSY) && (cnt == 4'd0));
   assign mem_we    = do_access && a_write && a_legal;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (a_strb[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= 4'd0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_strb  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_strb  <= in_strb;
                  req_ready <= 1'b0;
                  if (WAIT_STATES == 0) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= !a_legal;
                     rsp_rdata <= (a_legal && !a_write) ? mem[a_idx] : '0;
                  end else begin
                     state <= BUSY;
                     cnt   <= WAIT_INIT;
                  end
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !a_legal;
                  rsp_rdata <= (a_legal && !a_write) ? mem[a_idx] : '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) share stimulus, each checked every cycle
// against a transaction-level model; directed literal checks pin the model.
module tb_dmem_responder;

   localparam logic [31:0] BASE = 32'h0000_2000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_write, rsp_ready;
   logic [31:0] req_addr, req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
   logic [3:0]  req_wstrb = 4'hF;
`endif
   logic        rdy [2];
   logic        vld [2];
   logic        err [2];
   logic [31:0] rdata [2];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int WS = (g == 0) ? 2 : 0;

      dmem_responder #(.WAIT_STATES(WS)) dut (
         .clk(clk), .rst_n(rst_n),
         .req_valid(req_valid), .req_ready(rdy[g]), .req_write(req_write),
         .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
         .req_wstrb(req_wstrb),
`endif
         .rsp_valid(vld[g]), .rsp_ready(rsp_ready),
         .rsp_rdata(rdata[g]), .rsp_err(err[g])
      );

      // Model: a transaction accepted on edge n responds after edge n+WS; the result is
      // computed from the address rules at that moment against a plain word array.
      logic [31:0] mmem [64];
      bit          pend = 0, e_vld = 0, e_err = 0, m_write = 0;
      logic [31:0] e_rdata = '0, m_addr = '0, m_wdata = '0, off;
      logic [3:0]  m_strb = 4'hF;
      int unsigned cyc = 0, resp_at = 0;

      initial forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            pend = 0; e_vld = 0; e_err = 0; e_rdata = '0; cyc = 0;
         end else begin
            cyc++;
            if (e_vld) begin
               if (rsp_ready) begin e_vld = 0; pend = 0; end
            end else if (!pend && req_valid) begin
               pend = 1; m_write = req_write; m_addr = req_addr; m_wdata = req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
               m_strb = req_wstrb;
`else
               m_strb = 4'hF;
`endif
               resp_at = cyc + WS;
            end
            if (pend && !e_vld && cyc == resp_at) begin
               off = m_addr - BASE;
               if (m_addr < BASE || off >= 256 || off % 4 != 0) begin
                  e_err = 1; e_rdata = '0;
               end else if (m_write) begin
                  for (int b = 0; b < 4; b++)
                     if (m_strb[b]) mmem[off / 4][8*b +: 8] = m_wdata[8*b +: 8];
                  e_err = 0; e_rdata = '0;
               end else begin
                  e_err = 0; e_rdata = mmem[off / 4];
               end
               e_vld = 1;
            end
         end
      end

      initial forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            check($sformatf("u%0d.req_ready", g), {31'd0, rdy[g]}, {31'd0, !pend});
            check($sformatf("u%0d.rsp_valid", g), {31'd0, vld[g]}, {31'd0, e_vld});
            check($sformatf("u%0d.rsp_err", g),   {31'd0, err[g]}, {31'd0, e_err});
            check($sformatf("u%0d.rsp_rdata", g), rdata[g], e_rdata);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(rdy[0] && rdy[1]) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!(rdy[0] && rdy[1])) begin
         n_chk++; n_fail++;
         $display("FAIL wait_idle: responders not idle after %0d cycles", n);
      end
   endtask

   // Runs one transaction on instance 0 with rsp_ready high; lat counts edges from the accepting edge (=1).
   task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit e, output int lat);
      wait_idle();
      #1;
      req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1; rsp_ready = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) #1 req_valid = 1'b0;
      end while (!vld[0] && lat < 20);
      if (!vld[0]) begin
         n_chk++; n_fail++;
         $display("FAIL txn_timeout: no response for addr %h", a);
      end
      rd = rdata[0];
      e  = err[0];
      @(negedge clk);
   endtask

   logic [31:0] rd;
   bit          e;
   int          lat, acc, n;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset.req_ready", {31'd0, rdy[0]}, 32'd1);
      check("reset.rsp_valid", {31'd0, vld[0]}, 32'd0);
      check("reset.rsp_rdata", rdata[0], 32'd0);
      check("reset.rsp_err",   {31'd0, err[0]}, 32'd0);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 64; i++) txn(1'b1, BASE + 32'(i * 4), {16'hC0DE, 16'(i)}, rd, e, lat);

      txn(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, rd, e, lat);
      check("store.latency", lat, 32'd3);
      check("store.err", {31'd0, e}, 32'd0);
      check("store.rdata", rd, 32'd0);
      txn(1'b0, 32'h0000_2004, 32'd0, rd, e, lat);
      check("load.rdata", rd, 32'hDEAD_BEEF);
      check("load.err", {31'd0, e}, 32'd0);

      txn(1'b0, 32'h0000_1FFC, 32'd0, rd, e, lat);
      check("below_base.err", {31'd0, e}, 32'd1);
      check("below_base.rdata", rd, 32'd0);
      txn(1'b1, 32'h0000_2100, 32'hFFFF_FFFF, rd, e, lat);
      check("beyond_window.err", {31'd0, e}, 32'd1);
      txn(1'b0, 32'h0000_20FC, 32'd0, rd, e, lat);
      check("last_word.rdata", rd, 32'hC0DE_003F);
      txn(1'b0, 32'h0000_2000, 32'd0, rd, e, lat);
      check("first_word.rdata", rd, 32'hC0DE_0000);
      txn(1'b0, 32'h0000_2002, 32'd0, rd, e, lat);
      check("misaligned.err", {31'd0, e}, 32'd1);

      // Backpressure, with a second request held pending throughout.
      wait_idle();
      #1 req_write = 1'b0; req_addr = 32'h0000_2004; req_valid = 1'b1; rsp_ready = 1'b0;
      @(negedge clk);
      #1 req_addr = 32'h0000_2000;
      n = 0;
      while (!vld[0] && n < 20) begin @(negedge clk); n++; end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp.rsp_valid", {31'd0, vld[0]}, 32'd1);
         check("bp.rsp_rdata", rdata[0], 32'hDEAD_BEEF);
         check("bp.req_ready", {31'd0, rdy[0]}, 32'd0);
      end
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      check("bp.release_idle", {31'd0, rdy[0]}, 32'd1);
      @(negedge clk);
      check("bp.next_accepted", {31'd0, rdy[0]}, 32'd0);
      #1 req_valid = 1'b0;
      n = 0;
      while (!vld[0] && n < 20) begin @(negedge clk); n++; end
      check("bp.next_rdata", rdata[0], 32'hC0DE_0000);

      // Reset while instance 0 holds an uncommitted store.
      wait_idle();
      #1 req_write = 1'b1; req_addr = 32'h0000_2008; req_wdata = 32'h1234_5678; req_valid = 1'b1;
      @(negedge clk);
      #1 req_valid = 1'b0;
      check("busy.req_ready", {31'd0, rdy[0]}, 32'd0);
      #1 rst_n = 1'b0;
      #1 check("midreset.req_ready", {31'd0, rdy[0]}, 32'd1);
      check("midreset.rsp_valid", {31'd0, vld[0]}, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      txn(1'b0, 32'h0000_2008, 32'd0, rd, e, lat);
      check("midreset.no_write", rd, 32'hC0DE_0002);

      // Zero-wait instance under continuous requests: one accept every two cycles.
      wait_idle();
      #1 req_write = 1'b1; req_addr = 32'h0000_2010; req_wdata = 32'h0BAD_F00D; req_valid = 1'b1;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         if (rdy[1]) acc++;
         @(negedge clk);
      end
      check("ws0.accepts_in_10", acc, 32'd5);
      #1 req_valid = 1'b0;
      txn(1'b0, 32'h0000_2010, 32'd0, rd, e, lat);
      check("ws0.load_back", rd, 32'h0BAD_F00D);

`ifdef DMEM_BYTE_STROBE_EN
      txn(1'b1, 32'h0000_2020, 32'h1122_3344, rd, e, lat);
      req_wstrb = 4'b0101;
      txn(1'b1, 32'h0000_2020, 32'hAABB_CCDD, rd, e, lat);
      req_wstrb = 4'hF;
      txn(1'b0, 32'h0000_2020, 32'd0, rd, e, lat);
      check("strb.merge", rd, 32'h11BB_33DD);
      req_wstrb = 4'h0;
      txn(1'b1, 32'h0000_2020, 32'h9999_9999, rd, e, lat);
      check("strb.zero_err", {31'd0, e}, 32'd0);
      req_wstrb = 4'hF;
      txn(1'b0, 32'h0000_2020, 32'd0, rd, e, lat);
      check("strb.zero_unchanged", rd, 32'h11BB_33DD);
`endif

      // Random traffic; the per-cycle model comparison does the checking.
      wait_idle();
      for (int c = 0; c < 600; c++) begin
         #1;
         req_valid = ($urandom_range(0, 2) != 0);
         req_write = $urandom_range(0, 1) == 1;
         req_wdata = $urandom();
         case ($urandom_range(0, 7))
            6:       req_addr = BASE + 32'($urandom_range(0, 255)) | 32'd1;
            7:       req_addr = $urandom();
            default: req_addr = BASE + 32'($urandom_range(0, 63) * 4);
         endcase
`ifdef DMEM_BYTE_STROBE_EN
         req_wstrb = 4'($urandom_range(0, 15));
`endif
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      #1 req_valid = 1'b0; rsp_ready = 1'b1;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
